misao_xmem_unit: RTL and testbench

Parametrised load/store sequencer for MISA-O XMEM operations. Holds a bank of NUM_AR address registers and executes nibble (UL), byte or multi-byte little-endian accesses over the 8-bit memory port, one byte per cycle, with optional post-increment/decrement of the selected register. Sits between the core decode/ACC datapath and the external memory bus; generalises the fixed RA0/RA1, 8/16-bit XMEM path to arbitrary data width and register count.

---
 rtl/misao_xmem_unit.sv | 218 +++++++++++++++++++++
 tb/tb_misao_xmem_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misao_xmem_unit.sv
// MISA-O XMEM load/store sequencer: address-register bank plus a byte-serial
// little-endian access engine over the 8-bit memory port.
module misao_xmem_unit #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_AR = 2,
  parameter int unsigned SZ_W   = 3,
  localparam int unsigned NBYTES = DATA_W / 8,
  localparam int unsigned SEL_W  = $clog2(NUM_AR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [SZ_W-1:0]   req_size,
  input  logic [SEL_W-1:0]  req_ar_sel,
  input  logic [1:0]        req_post,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  input  logic              ar_wr_en,
  input  logic [SEL_W-1:0]  ar_wr_sel,
  input  logic [ADDR_W-1:0] ar_wr_data,
  input  logic [SEL_W-1:0]  ar_rd_sel,
  output logic [ADDR_W-1:0] ar_rd_data,
  output logic              mem_enable_read,
  output logic              mem_enable_write,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data_in,
  output logic [7:0]        mem_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ar_q [NUM_AR];
  logic [ADDR_W-1:0]   ar_d [NUM_AR];
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [SZ_W-1:0]     idx_q, idx_d, n_q, n_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                store_q, store_d, ul_q, ul_d;
  logic [1:0]          post_q, post_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic                done_q, done_d, err_q, err_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dout_q, dout_d;
  logic                ready_q, ready_d, busy_q, busy_d;
  logic [SZ_W-1:0]     req_n, next_idx;
  logic                req_ul;

  // Store byte for a given index; UL keeps only the low nibble.
  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] w,
                                           input logic [SZ_W-1:0] i,
                                           input logic ul);
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < int'(NBYTES); b++) begin
      if (i == SZ_W'(b)) r = w[8*b +: 8];
    end
    if (ul) r = {4'b0, r[3:0]};
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    ar_d      = ar_q;
    base_d    = base_q;
    idx_d     = idx_q;
    n_d       = n_q;
    sel_d     = sel_q;
    store_d   = store_q;
    ul_d      = ul_q;
    post_d    = post_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    dout_d    = dout_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    req_ul    = (req_size == '0);
    req_n     = req_ul ? SZ_W'(1) : req_size;
    next_idx  = idx_q + SZ_W'(1);

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (req_valid) begin
          sel_d   = req_ar_sel;
          store_d = req_store;
          post_d  = req_post;
          wdata_d = req_wdata;
          base_d  = ar_q[req_ar_sel];
          ul_d    = req_ul;
          n_d     = req_n;
          idx_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (req_size > SZ_W'(NBYTES)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
            addr_d  = ar_q[req_ar_sel];
            wr_en_d = req_store;
            rd_en_d = !req_store;
            if (req_store) begin
              dout_d = pick_byte(req_wdata, '0, req_ul);
            end else begin
              // Bytes beyond the access length read back as zero.
              for (int b = 0; b < int'(NBYTES); b++) begin
                if (SZ_W'(b) >= req_n) rd_data_d[8*b +: 8] = '0;
              end
            end
          end
        end
      end

      S_ACCESS: begin
        if (!store_q) begin
          for (int b = 0; b < int'(NBYTES); b++) begin
            if (idx_q == SZ_W'(b)) begin
              rd_data_d[8*b +: 8] = ul_q ? {4'b0, mem_data_in[3:0]} : mem_data_in;
            end
          end
        end
        if (idx_q == n_q - SZ_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (post_q == 2'b01) ar_d[sel_q] = base_q + ADDR_W'(n_q);
          if (post_q == 2'b10) ar_d[sel_q] = base_q - ADDR_W'(n_q);
        end else begin
          idx_d   = next_idx;
          addr_d  = base_q + ADDR_W'(next_idx);
          wr_en_d = store_q;
          rd_en_d = !store_q;
          if (store_q) dout_d = pick_byte(wdata_q, next_idx, ul_q);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    // Direct AR write overrides any post-update on the same edge.
    if (ar_wr_en) ar_d[ar_wr_sel] = ar_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < int'(NUM_AR); i++) ar_q[i] <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      n_q       <= '0;
      sel_q     <= '0;
      store_q   <= 1'b0;
      ul_q      <= 1'b0;
      post_q    <= 2'b00;
      wdata_q   <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_q      <= ar_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      sel_q     <= sel_d;
      store_q   <= store_d;
      ul_q      <= ul_d;
      post_q    <= post_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign req_ready        = ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign rd_data          = rd_data_q;
  assign mem_enable_read  = rd_en_q;
  assign mem_enable_write = wr_en_q;
  assign mem_addr         = addr_q;
  assign mem_data_out     = dout_q;
  assign ar_rd_data       = ar_q[ar_rd_sel];

endmodule

// File: tb/tb_misao_xmem_unit.sv
// Scoreboard bench for misao_xmem_unit with a byte-wide memory model.
module tb_misao_xmem_unit;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SZ_W   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_store;
  logic [SZ_W-1:0]   req_size;
  logic [0:0]        req_ar_sel;
  logic [1:0]        req_post;
  logic [DATA_W-1:0] req_wdata;
  logic              done, err, busy;
  logic [DATA_W-1:0] rd_data;
  logic              ar_wr_en;
  logic [0:0]        ar_wr_sel, ar_rd_sel;
  logic [ADDR_W-1:0] ar_wr_data, ar_rd_data;
  logic              mem_enable_read, mem_enable_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data_in, mem_data_out;

  logic [7:0] mem [0:32767];

  typedef struct packed {
    logic        store;
    logic        err;
    logic [15:0] rd;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  misao_xmem_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_AR(2), .SZ_W(SZ_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_ar_sel(req_ar_sel), .req_post(req_post),
    .req_wdata(req_wdata), .done(done), .err(err), .rd_data(rd_data), .busy(busy),
    .ar_wr_en(ar_wr_en), .ar_wr_sel(ar_wr_sel), .ar_wr_data(ar_wr_data),
    .ar_rd_sel(ar_rd_sel), .ar_rd_data(ar_rd_data),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  assign mem_data_in = mem[mem_addr];
  always @(posedge clk) if (mem_enable_write) mem[mem_addr] <= mem_data_out;

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (mem_enable_read && mem_enable_write) begin
      errors++;
      $display("FAIL strobes: read and write both high at %0t", $time);
    end
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_done: unexpected done at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (err !== mon_e.err) begin
          errors++;
          $display("FAIL sb_err: got %b want %b", err, mon_e.err);
        end
        if (!mon_e.store && !mon_e.err) begin
          checks++;
          if (rd_data !== mon_e.rd) begin
            errors++;
            $display("FAIL sb_rd_data: got %h want %h", rd_data, mon_e.rd);
          end
        end
      end
    end
  end

  task automatic ar_write(input logic [0:0] sel, input logic [ADDR_W-1:0] val);
    ar_wr_en = 1'b1; ar_wr_sel = sel; ar_wr_data = val;
    @(negedge clk);
    ar_wr_en = 1'b0;
  endtask

  task automatic check_ar(input string name, input logic [0:0] sel, input logic [ADDR_W-1:0] expv);
    ar_rd_sel = sel;
    #1;
    checks++;
    if (ar_rd_data !== expv) begin
      errors++;
      $display("FAIL %s: AR%0d got %h want %h", name, sel, ar_rd_data, expv);
    end
  endtask

  task automatic check_mem(input string name, input int addr, input logic [7:0] expv);
    checks++;
    if (mem[addr] !== expv) begin
      errors++;
      $display("FAIL %s: MEM[%h] got %h want %h", name, addr, mem[addr], expv);
    end
  endtask

  // Issue one request from a negedge; optionally inject an AR write in ACCESS cycle wr_cyc.
  task automatic issue(input string name, input logic st, input logic [SZ_W-1:0] sz,
                       input logic [0:0] sel, input logic [1:0] post,
                       input logic [15:0] wd, input logic [15:0] exp_rd,
                       input int wr_cyc, input logic [ADDR_W-1:0] wr_val);
    int cyc, nstb, n_exp;
    logic e_err;
    e_err = (sz > 3'd2);
    n_exp = (sz == 0) ? 1 : int'(sz);
    req_valid = 1'b1; req_store = st; req_size = sz; req_ar_sel = sel;
    req_post = post; req_wdata = wd;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b want 1", name, req_ready);
    end
    exp_q.push_back('{store: st, err: e_err, rd: exp_rd});
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; nstb = 0;
    while (1) begin
      ar_wr_en   = (wr_cyc != 0 && cyc == wr_cyc);
      ar_wr_sel  = sel;
      ar_wr_data = wr_val;
      if (done === 1'b1) break;
      if (cyc >= 20) begin
        errors++;
        $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
        break;
      end
      if (mem_enable_read || mem_enable_write) nstb++;
      @(negedge clk);
      cyc++;
    end
    ar_wr_en = 1'b0;
    checks++;
    if (cyc != (e_err ? 1 : n_exp + 1)) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, cyc, e_err ? 1 : n_exp + 1);
    end
    checks++;
    if (nstb != (e_err ? 0 : n_exp)) begin
      errors++;
      $display("FAIL %s_strobes: got %0d want %0d", name, nstb, e_err ? 0 : n_exp);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: ready %b busy %b want 1 0", name, req_ready, busy);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        rd_data !== 16'h0 || mem_enable_read !== 1'b0 || mem_enable_write !== 1'b0 ||
        mem_addr !== 15'h0 || mem_data_out !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready %b busy %b done %b err %b rd %h rs %b ws %b addr %h dout %h",
               req_ready, busy, done, err, rd_data, mem_enable_read, mem_enable_write,
               mem_addr, mem_data_out);
    end
    check_ar("reset_ar0", 1'b0, 15'h0);
    check_ar("reset_ar1", 1'b1, 15'h0);
  endtask

  task automatic test_ul_store;
    ar_write(1'b0, 15'h0080);
    issue("ul_store", 1'b1, 3'd0, 1'b0, 2'b01, 16'h00A5, 16'h0, 0, '0);
    check_mem("ul_store_mem", 'h80, 8'h05);
    check_ar("ul_store_ar", 1'b0, 15'h0081);
  endtask

  task automatic test_byte_ops;
    issue("byte_st1", 1'b1, 3'd1, 1'b0, 2'b01, 16'h005B, 16'h0, 0, '0);
    check_mem("byte_st1_mem", 'h81, 8'h5B);
    check_ar("byte_st1_ar", 1'b0, 15'h0082);
    issue("byte_st2", 1'b1, 3'd1, 1'b0, 2'b00, 16'hFF00, 16'h0, 0, '0);
    check_mem("byte_st2_mem", 'h82, 8'h00);
    issue("byte_ld_dec", 1'b0, 3'd1, 1'b0, 2'b10, 16'h0, 16'h0000, 0, '0);
    check_ar("byte_ld_dec_ar", 1'b0, 15'h0081);
    issue("ul_ld", 1'b0, 3'd0, 1'b0, 2'b00, 16'h0, 16'h000B, 0, '0);
    issue("byte_ld_p11", 1'b0, 3'd1, 1'b0, 2'b11, 16'h0, 16'h005B, 0, '0);
    check_ar("byte_ld_p11_ar", 1'b0, 15'h0081);
  endtask

  task automatic test_multi_byte;
    ar_write(1'b1, 15'h0090);
    issue("w16_st", 1'b1, 3'd2, 1'b1, 2'b01, 16'h1234, 16'h0, 0, '0);
    check_mem("w16_st_lo", 'h90, 8'h34);
    check_mem("w16_st_hi", 'h91, 8'h12);
    check_ar("w16_st_ar", 1'b1, 15'h0092);
    issue("w16_ld_dec", 1'b0, 3'd2, 1'b1, 2'b10, 16'h0, 16'hABCD, 0, '0);
    check_ar("w16_ld_dec_ar", 1'b1, 15'h0090);
    issue("w16_ld", 1'b0, 3'd2, 1'b1, 2'b00, 16'h0, 16'h1234, 0, '0);
    issue("b_ld_clear", 1'b0, 3'd1, 1'b1, 2'b00, 16'h0, 16'h0034, 0, '0);
  endtask

  task automatic test_wrap;
    ar_write(1'b0, 15'h7FFF);
    issue("wrap_st", 1'b1, 3'd2, 1'b0, 2'b01, 16'hBEEF, 16'h0, 0, '0);
    check_mem("wrap_lo", 'h7FFF, 8'hEF);
    check_mem("wrap_hi", 'h0000, 8'hBE);
    check_ar("wrap_inc_ar", 1'b0, 15'h0001);
    ar_write(1'b0, 15'h0000);
    issue("wrap_ld_dec", 1'b0, 3'd1, 1'b0, 2'b10, 16'h0, 16'h00BE, 0, '0);
    check_ar("wrap_dec_ar", 1'b0, 15'h7FFF);
  endtask

  task automatic test_illegal_size;
    issue("err_sz3", 1'b0, 3'd3, 1'b0, 2'b01, 16'h0, 16'h0, 0, '0);
    check_ar("err_sz3_ar", 1'b0, 15'h7FFF);
    issue("err_sz7", 1'b1, 3'd7, 1'b0, 2'b01, 16'h1111, 16'h0, 0, '0);
    check_mem("err_sz7_mem", 'h7FFF, 8'hEF);
    check_ar("err_sz7_ar", 1'b0, 15'h7FFF);
  endtask

  task automatic test_ar_collision;
    ar_write(1'b0, 15'h0200);
    issue("coll_st", 1'b1, 3'd1, 1'b0, 2'b01, 16'h0077, 16'h0, 1, 15'h0100);
    check_mem("coll_mem", 'h200, 8'h77);
    check_ar("coll_ar", 1'b0, 15'h0100);
    ar_write(1'b0, 15'h0300);
    issue("inflight_st", 1'b1, 3'd2, 1'b0, 2'b01, 16'h6655, 16'h0, 1, 15'h03F0);
    check_mem("inflight_lo", 'h300, 8'h55);
    check_mem("inflight_hi", 'h301, 8'h66);
    check_mem("inflight_stray", 'h3F1, 8'h00);
    check_ar("inflight_ar", 1'b0, 15'h0302);
  endtask

  task automatic test_rst_mid_access;
    ar_write(1'b0, 15'h0040);
    ar_write(1'b1, 15'h0044);
    req_valid = 1'b1; req_store = 1'b1; req_size = 3'd2; req_ar_sel = 1'b0;
    req_post = 2'b01; req_wdata = 16'hA5C3;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || mem_enable_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: ready %b busy %b ws %b want 1 0 0", req_ready, busy, mem_enable_write);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_done: done %b want 0", done);
      end
      @(negedge clk);
    end
    check_mem("rst_mid_b0", 'h40, 8'hC3);
    check_mem("rst_mid_b1", 'h41, 8'h22);
    check_ar("rst_mid_ar0", 1'b0, 15'h0);
    check_ar("rst_mid_ar1", 1'b1, 15'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = '0; req_ar_sel = '0;
    req_post = 2'b00; req_wdata = '0; ar_wr_en = 1'b0; ar_wr_sel = '0; ar_wr_data = '0;
    ar_rd_sel = '0;
    for (int a = 0; a < 32768; a++) mem[a] = 8'h00;
    mem['h82] = 8'hFF; mem['h92] = 8'hCD; mem['h93] = 8'hAB;
    mem['h40] = 8'h11; mem['h41] = 8'h22;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_ul_store();
    test_byte_ops();
    test_multi_byte();
    test_wrap();
    test_illegal_size();
    test_ar_collision();
    test_rst_mid_access();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d outstanding want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
